// File: rtl/hack_ram_arbiter.sv
// Arbiter sharing the single-port Hack data RAM between the CPU data port and the
// screen scan-out reader: CPU priority with a burst limit, registered memory side.
module hack_ram_arbiter #(
    parameter int ADDR_W    = 15,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_gnt,
    output logic              vid_rvalid,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, CPU, VID} state_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

    state_t              state_q, state_d;
    logic [3:0]          burst_cnt_q, burst_cnt_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                cpu_rvalid_q, cpu_rvalid_d;
    logic                vid_rvalid_q, vid_rvalid_d;
    logic                burst_full;

    // State register: reset discards every in-flight access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            burst_cnt_q  <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_rvalid_q <= 1'b0;
            vid_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            burst_cnt_q  <= burst_cnt_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            vid_rvalid_q <= vid_rvalid_d;
        end
    end

    // Grant and next-state logic; the video reader wins once the CPU has used up its burst.
    always_comb begin
        burst_full  = (burst_cnt_q == MAX_CNT);
        cpu_gnt     = !reset && cpu_req && !(vid_req && burst_full);
        vid_gnt     = !reset && vid_req && !cpu_gnt;
        burst_cnt_d = burst_cnt_q;
        if (!vid_req || vid_gnt) begin
            burst_cnt_d = '0;
        end else if (cpu_gnt && !burst_full) begin
            burst_cnt_d = burst_cnt_q + 4'd1;
        end
        state_d = IDLE;
        if (cpu_gnt) begin
            state_d = CPU;
        end else if (vid_gnt) begin
            state_d = VID;
        end
    end

    // Output logic: memory stage follows the grant, read-return stage follows the memory stage.
    always_comb begin
        mem_en_d     = cpu_gnt || vid_gnt;
        mem_we_d     = cpu_gnt && cpu_we;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if (cpu_gnt) begin
            mem_addr_d  = cpu_addr;
            mem_wdata_d = cpu_wdata;
        end else if (vid_gnt) begin
            mem_addr_d  = vid_addr;
        end
        cpu_rvalid_d = mem_en_q && !mem_we_q && (state_q == CPU);
        vid_rvalid_d = mem_en_q && !mem_we_q && (state_q == VID);
    end

    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign cpu_rvalid = cpu_rvalid_q;
    assign vid_rvalid = vid_rvalid_q;
    assign cpu_rdata  = cpu_rvalid_q ? mem_rdata : '0;
    assign vid_rdata  = vid_rvalid_q ? mem_rdata : '0;

endmodule

// File: tb/tb_hack_ram_arbiter.sv
// Self-checking bench for hack_ram_arbiter: directed vector table plus hand-written
// sequences for video bursts, request withdrawal and reset during traffic.
module tb_hack_ram_arbiter;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_req, cpu_we, vid_req;
    logic [ADDR_W-1:0] cpu_addr, vid_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt, cpu_rvalid, vid_gnt, vid_rvalid;
    logic [DATA_W-1:0] cpu_rdata, vid_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    logic [DATA_W-1:0] ram [0:32767];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        cpu_req;
        logic        cpu_we;
        logic [14:0] cpu_addr;
        logic [15:0] cpu_wdata;
        logic        vid_req;
        logic [14:0] vid_addr;
        logic        e_cpu_gnt;
        logic        e_vid_gnt;
        logic        e_mem_en;
        logic        e_mem_we;
        logic [14:0] e_mem_addr;
        logic [15:0] e_mem_wdata;
        logic        e_cpu_rvalid;
        logic [15:0] e_cpu_rdata;
        logic        e_vid_rvalid;
        logic [15:0] e_vid_rdata;
    } vec_t;

    vec_t vecs [0:39];
    int   n_vec = 0;

    hack_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .vid_req(vid_req), .vid_addr(vid_addr),
        .vid_gnt(vid_gnt), .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous RAM model: read data appears the cycle after mem_en.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_stimulus(input logic c_req, input logic c_we, input logic [14:0] c_addr,
                                  input logic [15:0] c_wdata, input logic v_req, input logic [14:0] v_addr);
        cpu_req   = c_req;
        cpu_we    = c_we;
        cpu_addr  = c_addr;
        cpu_wdata = c_wdata;
        vid_req   = v_req;
        vid_addr  = v_addr;
    endtask

    task automatic add_vec(input logic c_req, input logic c_we, input logic [14:0] c_addr,
                           input logic [15:0] c_wdata, input logic v_req, input logic [14:0] v_addr,
                           input logic g_c, input logic g_v, input logic m_en, input logic m_we,
                           input logic [14:0] m_addr, input logic [15:0] m_wdata,
                           input logic rv_c, input logic [15:0] rd_c,
                           input logic rv_v, input logic [15:0] rd_v);
        vecs[n_vec] = '{c_req, c_we, c_addr, c_wdata, v_req, v_addr, g_c, g_v,
                        m_en, m_we, m_addr, m_wdata, rv_c, rd_c, rv_v, rd_v};
        n_vec++;
    endtask

    task automatic do_reset();
        apply_stimulus(0, 0, '0, '0, 0, '0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) ram[i] = '0;
        for (int i = 0; i < 8; i++) ram[15'h4000 + i] = 16'hA000 + 16'(i);
        ram[15'h0020] = 16'hC020;
        ram[15'h0030] = 16'hC030;
        mem_rdata = '0;

        //            creq we caddr    cwdata   vreq vaddr    gC gV en we maddr    mwdata   rvC rdC      rvV rdV
        add_vec(1, 1, 15'h0010, 16'h1234, 0, 15'h0000, 1, 0, 0, 0, 15'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0000);
        add_vec(1, 0, 15'h0010, 16'h0000, 0, 15'h0000, 1, 0, 1, 1, 15'h0010, 16'h1234, 0, 16'h0000, 0, 16'h0000);
        add_vec(0, 0, 15'h0000, 16'h0000, 0, 15'h0000, 0, 0, 1, 0, 15'h0010, 16'h0000, 0, 16'h0000, 0, 16'h0000);
        add_vec(0, 0, 15'h0000, 16'h0000, 0, 15'h0000, 0, 0, 0, 0, 15'h0010, 16'h0000, 1, 16'h1234, 0, 16'h0000);
        add_vec(0, 0, 15'h0000, 16'h0000, 0, 15'h0000, 0, 0, 0, 0, 15'h0010, 16'h0000, 0, 16'h0000, 0, 16'h0000);
        // Simultaneous requests after idle: CPU first, video next.
        add_vec(1, 0, 15'h0020, 16'h0000, 1, 15'h4000, 1, 0, 0, 0, 15'h0010, 16'h0000, 0, 16'h0000, 0, 16'h0000);
        add_vec(0, 0, 15'h0000, 16'h0000, 1, 15'h4000, 0, 1, 1, 0, 15'h0020, 16'h0000, 0, 16'h0000, 0, 16'h0000);
        add_vec(0, 0, 15'h0000, 16'h0000, 0, 15'h0000, 0, 0, 1, 0, 15'h4000, 16'h0000, 1, 16'hC020, 0, 16'h0000);
        add_vec(0, 0, 15'h0000, 16'h0000, 0, 15'h0000, 0, 0, 0, 0, 15'h4000, 16'h0000, 0, 16'h0000, 1, 16'hA000);
        add_vec(0, 0, 15'h0000, 16'h0000, 0, 15'h0000, 0, 0, 0, 0, 15'h4000, 16'h0000, 0, 16'h0000, 0, 16'h0000);
        // Both held: C,C,C,C,V twice.
        add_vec(1, 0, 15'h0030, 16'h0000, 1, 15'h4001, 1, 0, 0, 0, 15'h4000, 16'h0000, 0, 16'h0000, 0, 16'h0000);
        add_vec(1, 0, 15'h0030, 16'h0000, 1, 15'h4001, 1, 0, 1, 0, 15'h0030, 16'h0000, 0, 16'h0000, 0, 16'h0000);
        add_vec(1, 0, 15'h0030, 16'h0000, 1, 15'h4001, 1, 0, 1, 0, 15'h0030, 16'h0000, 1, 16'hC030, 0, 16'h0000);
        add_vec(1, 0, 15'h0030, 16'h0000, 1, 15'h4001, 1, 0, 1, 0, 15'h0030, 16'h0000, 1, 16'hC030, 0, 16'h0000);
        add_vec(1, 0, 15'h0030, 16'h0000, 1, 15'h4001, 0, 1, 1, 0, 15'h0030, 16'h0000, 1, 16'hC030, 0, 16'h0000);
        add_vec(1, 0, 15'h0030, 16'h0000, 1, 15'h4001, 1, 0, 1, 0, 15'h4001, 16'h0000, 1, 16'hC030, 0, 16'h0000);
        add_vec(1, 0, 15'h0030, 16'h0000, 1, 15'h4001, 1, 0, 1, 0, 15'h0030, 16'h0000, 0, 16'h0000, 1, 16'hA001);
        add_vec(1, 0, 15'h0030, 16'h0000, 1, 15'h4001, 1, 0, 1, 0, 15'h0030, 16'h0000, 1, 16'hC030, 0, 16'h0000);
        add_vec(1, 0, 15'h0030, 16'h0000, 1, 15'h4001, 1, 0, 1, 0, 15'h0030, 16'h0000, 1, 16'hC030, 0, 16'h0000);
        add_vec(1, 0, 15'h0030, 16'h0000, 1, 15'h4001, 0, 1, 1, 0, 15'h0030, 16'h0000, 1, 16'hC030, 0, 16'h0000);
        add_vec(0, 0, 15'h0000, 16'h0000, 0, 15'h0000, 0, 0, 1, 0, 15'h4001, 16'h0000, 1, 16'hC030, 0, 16'h0000);
        add_vec(0, 0, 15'h0000, 16'h0000, 0, 15'h0000, 0, 0, 0, 0, 15'h4001, 16'h0000, 0, 16'h0000, 1, 16'hA001);
        add_vec(0, 0, 15'h0000, 16'h0000, 0, 15'h0000, 0, 0, 0, 0, 15'h4001, 16'h0000, 0, 16'h0000, 0, 16'h0000);
        // CPU write then video read of the same address sees the new data.
        add_vec(1, 1, 15'h4002, 16'hBEEF, 1, 15'h4002, 1, 0, 0, 0, 15'h4001, 16'h0000, 0, 16'h0000, 0, 16'h0000);
        add_vec(0, 0, 15'h0000, 16'h0000, 1, 15'h4002, 0, 1, 1, 1, 15'h4002, 16'hBEEF, 0, 16'h0000, 0, 16'h0000);
        add_vec(0, 0, 15'h0000, 16'h0000, 0, 15'h0000, 0, 0, 1, 0, 15'h4002, 16'h0000, 0, 16'h0000, 0, 16'h0000);
        add_vec(0, 0, 15'h0000, 16'h0000, 0, 15'h0000, 0, 0, 0, 0, 15'h4002, 16'h0000, 0, 16'h0000, 1, 16'hBEEF);
        add_vec(0, 0, 15'h0000, 16'h0000, 0, 15'h0000, 0, 0, 0, 0, 15'h4002, 16'h0000, 0, 16'h0000, 0, 16'h0000);

        apply_stimulus(0, 0, '0, '0, 0, '0);
        reset = 1'b1;
        #1;
        check_output("reset_mem_en", 32'(mem_en), 0);
        check_output("reset_mem_addr", 32'(mem_addr), 0);
        check_output("reset_cpu_rvalid", 32'(cpu_rvalid), 0);
        check_output("reset_vid_rvalid", 32'(vid_rvalid), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Video-only reads over 0x4000..0x4007.
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            if (k < 8) apply_stimulus(0, 0, '0, '0, 1, 15'h4000 + 15'(k));
            else       apply_stimulus(0, 0, '0, '0, 0, '0);
            #1;
            check_output("vburst_vid_gnt", 32'(vid_gnt), 32'(k < 8));
            check_output("vburst_cpu_gnt", 32'(cpu_gnt), 0);
            check_output("vburst_mem_en", 32'(mem_en), 32'(k >= 1 && k <= 8));
            if (k >= 1 && k <= 8) check_output("vburst_mem_addr", 32'(mem_addr), 32'h4000 + 32'(k - 1));
            check_output("vburst_vid_rvalid", 32'(vid_rvalid), 32'(k >= 2 && k <= 9));
            if (k >= 2 && k <= 9) check_output("vburst_vid_rdata", 32'(vid_rdata), 32'hA000 + 32'(k - 2));
            check_output("vburst_cpu_rvalid", 32'(cpu_rvalid), 0);
        end

        do_reset();

        for (int i = 0; i < n_vec; i++) begin
            @(negedge clk);
            apply_stimulus(vecs[i].cpu_req, vecs[i].cpu_we, vecs[i].cpu_addr, vecs[i].cpu_wdata,
                           vecs[i].vid_req, vecs[i].vid_addr);
            #1;
            check_output($sformatf("v%0d_cpu_gnt", i), 32'(cpu_gnt), 32'(vecs[i].e_cpu_gnt));
            check_output($sformatf("v%0d_vid_gnt", i), 32'(vid_gnt), 32'(vecs[i].e_vid_gnt));
            check_output($sformatf("v%0d_mem_en", i), 32'(mem_en), 32'(vecs[i].e_mem_en));
            check_output($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].e_mem_we));
            check_output($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].e_mem_addr));
            if (vecs[i].e_mem_we)
                check_output($sformatf("v%0d_mem_wdata", i), 32'(mem_wdata), 32'(vecs[i].e_mem_wdata));
            check_output($sformatf("v%0d_cpu_rvalid", i), 32'(cpu_rvalid), 32'(vecs[i].e_cpu_rvalid));
            if (vecs[i].e_cpu_rvalid)
                check_output($sformatf("v%0d_cpu_rdata", i), 32'(cpu_rdata), 32'(vecs[i].e_cpu_rdata));
            check_output($sformatf("v%0d_vid_rvalid", i), 32'(vid_rvalid), 32'(vecs[i].e_vid_rvalid));
            if (vecs[i].e_vid_rvalid)
                check_output($sformatf("v%0d_vid_rdata", i), 32'(vid_rdata), 32'(vecs[i].e_vid_rdata));
        end

        // Withdrawn video pulse must leave burst count at zero: full C,C,C,C,V pattern follows.
        for (int w = 0; w < 10; w++) begin
            @(negedge clk);
            case (w)
                0:       apply_stimulus(1, 0, 15'h0030, '0, 1, 15'h4005);
                1:       apply_stimulus(1, 0, 15'h0030, '0, 0, '0);
                2, 3, 4, 5, 6: apply_stimulus(1, 0, 15'h0030, '0, 1, 15'h4006);
                default: apply_stimulus(0, 0, '0, '0, 0, '0);
            endcase
            #1;
            check_output($sformatf("wd%0d_cpu_gnt", w), 32'(cpu_gnt), 32'(w <= 5));
            check_output($sformatf("wd%0d_vid_gnt", w), 32'(vid_gnt), 32'(w == 6));
            check_output($sformatf("wd%0d_vid_rvalid", w), 32'(vid_rvalid), 32'(w == 8));
            if (w == 8) check_output("wd_vid_rdata", 32'(vid_rdata), 32'hA006);
            if (w >= 1 && w <= 6) check_output($sformatf("wd%0d_mem_addr", w), 32'(mem_addr), 32'h0030);
        end

        // Reset with a read returning and a write in the memory stage.
        @(negedge clk);
        apply_stimulus(1, 0, 15'h0030, '0, 0, '0);
        #1 check_output("rst_seq_gnt0", 32'(cpu_gnt), 1);
        @(negedge clk);
        apply_stimulus(1, 1, 15'h0040, 16'h7777, 0, '0);
        #1 check_output("rst_seq_rd_inflight", 32'(mem_en), 1);
        @(negedge clk);
        apply_stimulus(0, 0, '0, '0, 0, '0);
        #1;
        check_output("rst_seq_we_inflight", 32'(mem_we), 1);
        check_output("rst_seq_rvalid_pre", 32'(cpu_rvalid), 1);
        reset = 1'b1;
        #1;
        check_output("rst_mid_mem_en", 32'(mem_en), 0);
        check_output("rst_mid_mem_we", 32'(mem_we), 0);
        check_output("rst_mid_mem_addr", 32'(mem_addr), 0);
        check_output("rst_mid_mem_wdata", 32'(mem_wdata), 0);
        check_output("rst_mid_cpu_rvalid", 32'(cpu_rvalid), 0);
        check_output("rst_mid_cpu_rdata", 32'(cpu_rdata), 0);
        check_output("rst_mid_vid_rvalid", 32'(vid_rvalid), 0);
        check_output("rst_mid_vid_rdata", 32'(vid_rdata), 0);
        check_output("rst_mid_gnts", 32'({cpu_gnt, vid_gnt}), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            #1;
            check_output($sformatf("rst_post%0d_cpu_rvalid", r), 32'(cpu_rvalid), 0);
            check_output($sformatf("rst_post%0d_mem_en", r), 32'(mem_en), 0);
        end
        check_output("rst_no_partial_write", 32'(ram[15'h0040]), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Grants must be mutually exclusive in every sampled cycle.
    always @(negedge clk) begin
        #2;
        if (cpu_gnt && vid_gnt) begin
            checks++;
            errors++;
            $display("[TB] FAIL gnt_exclusive: cpu_gnt=%0b vid_gnt=%0b, expected not both 1", cpu_gnt, vid_gnt);
        end
    end

endmodule
